// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: state encoding, wait-counter width and byte-to-word
// address helper shared by the responder and its RAM.
package data_ram_responder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    // Callers truncate the result to their own word-address width.
    function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_word_array.sv
// ram_word_array: single-port 32-bit word RAM with synchronous write and
// asynchronous read.
module ram_word_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: answers core data-memory requests from a word RAM,
// inserting WAIT_CYCLES wait states reported on ram_stall.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cs,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        ram_stall
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, cur_addr, ram_addr;
    logic [31:0]             data_q, data_d, wdata, rdata;
    logic                    op_q, op_d, ren_q, ren_d;
    logic                    req, we, rd_en, stall;

    always_comb begin
        req      = ram_cs & (mem_ren | mem_wen);
        cur_addr = ADDR_WIDTH'(word_idx(mem_addr));
        ram_addr = (state_q == IDLE) ? cur_addr : addr_q;
        wdata    = (state_q == IDLE) ? mem_dout : data_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        ren_d    = ren_q;
        stall    = 1'b0;
        rd_en    = 1'b0;
        we       = 1'b0;
        if (state_q == IDLE) begin
            if (req && WAIT_CYCLES == 0) begin
                rd_en = mem_ren;
                we    = mem_wen;
            end else if (req) begin
                stall   = 1'b1;
                state_d = BUSY;
                cnt_d   = CNT_INIT;
                addr_d  = cur_addr;
                data_d  = mem_dout;
                op_d    = mem_wen;
                ren_d   = mem_ren;
            end
        end else if (!req) begin
            state_d = IDLE;
        end else if (cnt_q != '0) begin
            stall = 1'b1;
            cnt_d = cnt_q - 1'b1;
        end else begin
            rd_en   = ren_q;
            we      = op_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            ren_q   <= ren_d;
        end
    end

    // Outputs and write enable are masked by rst so reset acts without a clock edge.
    assign ram_stall = stall & ~rst;
    assign mem_din   = (rd_en & ~rst) ? rdata : '0;

    ram_word_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (we & ~rst),
        .waddr (ram_addr),
        .wdata (wdata),
        .raddr (ram_addr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: drives a zero-wait and a two-wait responder with the
// same stimulus; a scoreboard compares each against a per-cycle access model.
module tb_data_ram_responder;

    localparam int AW = 4;

    typedef struct packed {
        logic        stall;
        logic [31:0] din;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_cs = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [31:0] mem_addr = '0, mem_dout = '0;
    logic [31:0] din0, din2;
    logic        stall0, stall2;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // Model state per instance: index 0 is WAIT=0, index 1 is WAIT=2.
    int          wv[2] = '{0, 2};
    bit          pend[2];
    int          k[2];
    logic [AW-1:0] la[2];
    logic [31:0] ld[2];
    bit          lw[2], lr[2];
    logic [31:0] mm[2][2**AW];

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ram_cs(ram_cs), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(din0), .ram_stall(stall0)
    );

    data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .ram_cs(ram_cs), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(din2), .ram_stall(stall2)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // An access starts when a request appears with nothing pending, stalls for
    // wv cycles, then completes; a dropped request abandons it.
    task automatic model(int i, output exp_t e);
        bit            req = ram_cs && (mem_ren || mem_wen);
        logic [AW-1:0] idx = mem_addr[AW+1:2];
        e = '0;
        if (pend[i] && !req) begin
            pend[i] = 0;
            return;
        end
        if (!pend[i] && req) begin
            pend[i] = 1; k[i] = 0; la[i] = idx; ld[i] = mem_dout; lw[i] = mem_wen; lr[i] = mem_ren;
        end
        if (!pend[i]) return;
        if (k[i] < wv[i]) begin
            e.stall = 1'b1;
            k[i]++;
            return;
        end
        e.din = lr[i] ? mm[i][la[i]] : 32'h0;
        if (lw[i]) mm[i][la[i]] = ld[i];
        pend[i] = 0;
    endtask

    task automatic step(bit cs, bit ren, bit wen, logic [31:0] a, logic [31:0] d, bit pulse);
        exp_t e;
        @(posedge clk);
        #1;
        ram_cs = cs; mem_ren = ren; mem_wen = wen; mem_addr = a; mem_dout = d;
        if (pulse) begin
            #1 rst = 1'b1;
            #1;
            check("async rst stall2", 32'(stall2), 32'h0);
            check("async rst din2", din2, 32'h0);
            check("async rst stall0", 32'(stall0), 32'h0);
            check("async rst din0", din0, 32'h0);
            rst = 1'b0;
            pend[0] = 0;
            pend[1] = 0;
        end
        model(0, e); q0.push_back(e);
        model(1, e); q1.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic bd(string name, int w);
        check({name, " ram0"}, dut0.u_ram.mem[w], mm[0][w]);
        check({name, " ram2"}, dut2.u_ram.mem[w], mm[1][w]);
    endtask

    always @(negedge clk) begin
        if (q0.size() != 0) begin
            e0 = q0.pop_front();
            check("w0 ram_stall", 32'(stall0), 32'(e0.stall));
            check("w0 mem_din", din0, e0.din);
        end
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check("w2 ram_stall", 32'(stall2), 32'(e1.stall));
            check("w2 mem_din", din2, e1.din);
        end
    end

    initial begin
        logic [31:0] d;
        int          len;
        ram_cs = 1'b1; mem_ren = 1'b1;
        #2;
        check("reset stall2", 32'(stall2), 32'h0);
        check("reset din2", din2, 32'h0);
        check("reset stall0", 32'(stall0), 32'h0);
        check("reset din0", din0, 32'h0);
        ram_cs = 1'b0; mem_ren = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int w = 0; w < 2**AW; w++) begin
            d = $urandom;
            repeat (3) step(1, 0, 1, 32'(w * 4), d, 0);
        end
        idle();
        repeat (3) step(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        idle();
        check("write 0x10 ram2", dut2.u_ram.mem[4], 32'hDEAD_BEEF);
        bd("write 0x10", 4);
        repeat (3) step(1, 1, 0, 32'h0000_0010, 32'h0, 0);
        idle();
        step(1, 0, 1, 32'h0000_0020, 32'h1234_5678, 0);
        step(1, 1, 0, 32'h0000_0020, 32'h0, 0);
        idle();
        check("b2b write ram0", dut0.u_ram.mem[8], 32'h1234_5678);
        bd("b2b", 8);
        step(1, 0, 1, 32'h0000_0008, 32'hAAAA_5555, 0);
        step(1, 0, 0, 32'h0000_0008, 32'hAAAA_5555, 0);
        idle();
        bd("abort", 2);
        step(1, 0, 1, 32'h0000_000C, 32'h1357_9BDF, 0);
        step(1, 0, 1, 32'h0000_000C, 32'h1357_9BDF, 1);
        idle();
        bd("rst discard", 3);
        repeat (3) step(1, 1, 0, 32'h0000_000C, 32'h0, 0);
        repeat (2) step(0, 1, 0, 32'h0000_0010, 32'h0, 0);
        repeat (3) step(1, 1, 1, 32'hFFFF_F004, 32'h0BAD_F00D, 0);
        idle();
        bd("wrap", 1);
        for (int n = 0; n < 110; n++) begin
            len = $urandom_range(1, 4);
            d = $urandom;
            begin
                bit          cs = ($urandom % 8) != 0;
                bit          rn = 1'($urandom);
                bit          wn = 1'($urandom);
                logic [31:0] a = $urandom;
                for (int c = 0; c < len; c++) step(cs, rn, wn, a, d, c == 1 && ($urandom % 12) == 0);
            end
            if ($urandom % 3 == 0) idle();
        end
        repeat (3) idle();
        for (int w = 0; w < 2**AW; w++) bd("final", w);
        @(negedge clk);
        #1;
        check("queue0 drained", q0.size(), 32'h0);
        check("queue1 drained", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
